// File: rtl/ram_dual_port_be.sv
`default_nettype none
// ============================================================================
// Module   : ram_dual_port_be
// Purpose  : Simple-dual-port RAM with one byte-enabled write port and one
//            independent, valid-qualified read port. A built-in clear
//            sequencer zeroes every word after reset or on request.
// Ports    : clk_i      - single clock, rising edge
//            rst_i      - synchronous reset, active-high
//            clear_i    - pulse: start zeroing all words (ignored while busy)
//            busy_o     - clear in progress; both ports ignored
//            wr_en_i    - write request
//            wr_addr_i  - write address
//            wr_be_i    - byte enables, bit k covers data[8k+7:8k]
//            wr_data_i  - write data
//            rd_en_i    - read request
//            rd_addr_i  - read address
//            rd_data_o  - read data, holds its value while rd_valid_o=0
//            rd_valid_o - one-cycle pulse per accepted read
// Options  : RAM_BYPASS_EN - when defined, a same-cycle read and write to the
//            same address return the merged write data (write-first);
//            otherwise the old word is returned (read-first).
// Revision : 1.0 - initial release
// ============================================================================
module ram_dual_port_be #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int MEMORY_DEPTH  = 32,
    parameter int OUTPUT_REG    = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    output logic                      busy_o,
    input  logic                      wr_en_i,
    input  logic [ADDRESS_WIDTH-1:0]  wr_addr_i,
    input  logic [DATA_WIDTH/8-1:0]   wr_be_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    input  logic                      rd_en_i,
    input  logic [ADDRESS_WIDTH-1:0]  rd_addr_i,
    output logic [DATA_WIDTH-1:0]     rd_data_o,
    output logic                      rd_valid_o
);

    localparam int                     c_BYTES     = DATA_WIDTH / 8;
    // One extra bit so a depth of exactly 2**ADDRESS_WIDTH is representable.
    localparam logic [ADDRESS_WIDTH:0] c_DEPTH     = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] c_LAST_ADDR = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

    logic [DATA_WIDTH-1:0]    r_mem [MEMORY_DEPTH];
    logic [0:0]               r_state;
    logic                     r_busy;
    logic [ADDRESS_WIDTH-1:0] r_clr_addr;

    logic                     r_s1_valid;
    logic [DATA_WIDTH-1:0]    r_s1_data;

    logic                     w_ready;
    logic                     w_wr_in_range;
    logic                     w_rd_in_range;
    logic                     w_wr_fire;
    logic                     w_rd_fire;
    logic [DATA_WIDTH-1:0]    w_rd_word;

    assign w_ready       = (r_state == c_ST_READY);
    assign w_wr_in_range = ({1'b0, wr_addr_i} < c_DEPTH);
    assign w_rd_in_range = ({1'b0, rd_addr_i} < c_DEPTH);
    // Out-of-range writes are dropped; out-of-range reads still complete.
    assign w_wr_fire     = w_ready & wr_en_i & w_wr_in_range;
    assign w_rd_fire     = w_ready & rd_en_i;
    assign busy_o        = r_busy;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_CLEAR;
            r_busy     <= 1'b1;
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                c_ST_CLEAR: begin
                    if (r_clr_addr == c_LAST_ADDR) begin
                        r_state    <= c_ST_READY;
                        r_busy     <= 1'b0;
                        r_clr_addr <= '0;
                    end else begin
                        r_clr_addr <= r_clr_addr + ADDRESS_WIDTH'(1);
                    end
                end
                default: begin
                    if (clear_i) begin
                        r_state    <= c_ST_CLEAR;
                        r_busy     <= 1'b1;
                        r_clr_addr <= '0;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage: the clear sequencer owns the array while it runs. A write
    // coinciding with clear_i lands now and is zeroed by the sweep later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (r_state == c_ST_CLEAR) begin
                r_mem[r_clr_addr] <= '0;
            end else if (w_wr_fire) begin
                for (int k = 0; k < c_BYTES; k++) begin
                    if (wr_be_i[k]) begin
                        r_mem[wr_addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read word selection
    // ------------------------------------------------------------------
`ifdef RAM_BYPASS_EN
    always_comb begin
        w_rd_word = w_rd_in_range ? r_mem[rd_addr_i] : '0;
        // w_wr_fire implies an in-range write address, so an address match
        // also implies an in-range read.
        if (w_wr_fire && (wr_addr_i == rd_addr_i)) begin
            for (int k = 0; k < c_BYTES; k++) begin
                if (wr_be_i[k]) begin
                    w_rd_word[8*k +: 8] = wr_data_i[8*k +: 8];
                end
            end
        end
    end
`else
    assign w_rd_word = w_rd_in_range ? r_mem[rd_addr_i] : '0;
`endif

    // ------------------------------------------------------------------
    // Read pipeline: data registers only load on a valid beat so the
    // output holds its last value between reads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic                  r_s2_valid;
            logic [DATA_WIDTH-1:0] r_s2_data;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign rd_valid_o = r_s2_valid;
            assign rd_data_o  = r_s2_data;
        end else begin : g_out_direct
            assign rd_valid_o = r_s1_valid;
            assign rd_data_o  = r_s1_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_dual_port_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_dual_port_be
// Purpose  : Self-checking bench for ram_dual_port_be. Two instances share
//            the same stimulus: DUT 0 uses the default geometry with a
//            1-cycle read, DUT 1 has 20 words with the output register.
//            A behavioural model (word arrays plus a delivery schedule)
//            predicts busy, valid and data for each instance every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_dual_port_be;

    logic        r_clk = 1'b0;
    logic        r_rst = 1'b1;
    logic        r_clear = 1'b0;
    logic        r_wr_en = 1'b0;
    logic [4:0]  r_wr_addr = '0;
    logic [3:0]  r_wr_be = '0;
    logic [31:0] r_wr_data = '0;
    logic        r_rd_en = 1'b0;
    logic [4:0]  r_rd_addr = '0;

    logic [1:0]  w_busy;
    logic [1:0]  w_rd_valid;
    logic [31:0] w_rd_data [2];

    int n_total = 0;
    int n_bad   = 0;

    always #5 r_clk = ~r_clk;

    ram_dual_port_be #(
        .ADDRESS_WIDTH (5),
        .DATA_WIDTH    (32),
        .MEMORY_DEPTH  (32),
        .OUTPUT_REG    (0)
    ) u_dut0 (
        .clk_i      (r_clk),
        .rst_i      (r_rst),
        .clear_i    (r_clear),
        .busy_o     (w_busy[0]),
        .wr_en_i    (r_wr_en),
        .wr_addr_i  (r_wr_addr),
        .wr_be_i    (r_wr_be),
        .wr_data_i  (r_wr_data),
        .rd_en_i    (r_rd_en),
        .rd_addr_i  (r_rd_addr),
        .rd_data_o  (w_rd_data[0]),
        .rd_valid_o (w_rd_valid[0])
    );

    ram_dual_port_be #(
        .ADDRESS_WIDTH (5),
        .DATA_WIDTH    (32),
        .MEMORY_DEPTH  (20),
        .OUTPUT_REG    (1)
    ) u_dut1 (
        .clk_i      (r_clk),
        .rst_i      (r_rst),
        .clear_i    (r_clear),
        .busy_o     (w_busy[1]),
        .wr_en_i    (r_wr_en),
        .wr_addr_i  (r_wr_addr),
        .wr_be_i    (r_wr_be),
        .wr_data_i  (r_wr_data),
        .rd_en_i    (r_rd_en),
        .rd_addr_i  (r_rd_addr),
        .rd_data_o  (w_rd_data[1]),
        .rd_valid_o (w_rd_valid[1])
    );

    // ---------------- reference model ----------------
    int          m_depth [2] = '{32, 20};
    int          m_lat   [2] = '{1, 2};
    logic [31:0] m_mem [2][32];
    int          m_busy_left [2];
    bit          m_pv [2][4];          // scheduled deliveries, slot = edge % 4
    logic [31:0] m_pd [2][4];
    logic        m_exp_v [2];
    logic [31:0] m_exp_d [2];
    int          m_edge = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            logic [31:0] w;
            int          slot;
            if (r_rst) begin
                m_busy_left[d] = m_depth[d];
                for (int s = 0; s < 4; s++) m_pv[d][s] = 1'b0;
                m_exp_v[d] = 1'b0;
                m_exp_d[d] = '0;
            end else begin
                if (m_busy_left[d] > 0) begin
                    m_mem[d][m_depth[d] - m_busy_left[d]] = '0;
                    m_busy_left[d]--;
                end else begin
                    if (r_rd_en) begin
                        if (int'(r_rd_addr) < m_depth[d]) begin
                            w = m_mem[d][r_rd_addr];
`ifdef RAM_BYPASS_EN
                            if (r_wr_en && r_wr_addr == r_rd_addr)
                                for (int k = 0; k < 4; k++)
                                    if (r_wr_be[k]) w[8*k +: 8] = r_wr_data[8*k +: 8];
`endif
                        end else begin
                            w = '0;
                        end
                        slot = (m_edge + m_lat[d] - 1) % 4;
                        m_pv[d][slot] = 1'b1;
                        m_pd[d][slot] = w;
                    end
                    if (r_wr_en && int'(r_wr_addr) < m_depth[d])
                        for (int k = 0; k < 4; k++)
                            if (r_wr_be[k]) m_mem[d][r_wr_addr][8*k +: 8] = r_wr_data[8*k +: 8];
                    if (r_clear) m_busy_left[d] = m_depth[d];
                end
                slot = m_edge % 4;
                if (m_pv[d][slot]) begin
                    m_exp_v[d]    = 1'b1;
                    m_exp_d[d]    = m_pd[d][slot];
                    m_pv[d][slot] = 1'b0;
                end else begin
                    m_exp_v[d] = 1'b0;
                end
            end
        end
        m_edge++;
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy%0d", d),  32'(w_busy[d]),     32'(m_busy_left[d] > 0));
            chk($sformatf("valid%0d", d), 32'(w_rd_valid[d]), 32'(m_exp_v[d]));
            chk($sformatf("data%0d", d),  w_rd_data[d],       m_exp_d[d]);
        end
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge,
    // then all request strobes drop back to idle.
    task automatic tick();
        @(posedge r_clk);
        model_edge();
        @(negedge r_clk);
        check_all();
        r_rst   = 1'b0;
        r_clear = 1'b0;
        r_wr_en = 1'b0;
        r_rd_en = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        r_wr_en = 1'b1; r_wr_addr = 5'(a); r_wr_data = d; r_wr_be = be;
        tick();
    endtask

    task automatic rd(input int a);
        r_rd_en = 1'b1; r_rd_addr = 5'(a);
        tick();
    endtask

    initial begin
        int cnt;

        // reset and initial clear length
        r_rst = 1'b1;
        tick();
        cnt = 0;
        while (w_busy[0] === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("clr_len_reset", 32'(cnt), 32'd32);

        rd(31);
        chk("rd31_valid", 32'(w_rd_valid[0]), 32'd1);
        chk("rd31_data", w_rd_data[0], 32'h0);

        // byte-enable merge
        wr(5, 32'hDEADBEEF, 4'hF);
        wr(5, 32'h11223344, 4'h5);
        rd(5);
        chk("be_merge", w_rd_data[0], 32'hDE22BE44);

        // back-to-back reads through the 2-cycle instance
        wr(1, 32'hA, 4'hF);
        wr(2, 32'hB, 4'hF);
        wr(3, 32'hC, 4'hF);
        rd(1);
        chk("pipe_v0", 32'(w_rd_valid[1]), 32'd0);
        rd(2);
        chk("pipe_v1", 32'(w_rd_valid[1]), 32'd1);
        chk("pipe_d1", w_rd_data[1], 32'hA);
        rd(3);
        chk("pipe_d2", w_rd_data[1], 32'hB);
        tick();
        chk("pipe_v3", 32'(w_rd_valid[1]), 32'd1);
        chk("pipe_d3", w_rd_data[1], 32'hC);
        tick();
        chk("pipe_v4", 32'(w_rd_valid[1]), 32'd0);
        chk("pipe_hold", w_rd_data[1], 32'hC);

        // same-address read and write in one cycle
        wr(5, 32'h0, 4'hF);
        r_wr_en = 1'b1; r_wr_addr = 5'd5; r_wr_data = 32'h12345678; r_wr_be = 4'hF;
        r_rd_en = 1'b1; r_rd_addr = 5'd5;
        tick();
`ifdef RAM_BYPASS_EN
        chk("rw_same", w_rd_data[0], 32'h12345678);
`else
        chk("rw_same", w_rd_data[0], 32'h0);
`endif
        rd(5);
        chk("rw_after", w_rd_data[0], 32'h12345678);

        // clear with a concurrent read
        for (int i = 0; i < 32; i++) wr(i, 32'h01010101 * (i + 1), 4'hF);
        wr(2, 32'h77, 4'hF);
        r_clear = 1'b1; r_rd_en = 1'b1; r_rd_addr = 5'd2;
        tick();
        chk("clr_rd_valid", 32'(w_rd_valid[0]), 32'd1);
        chk("clr_rd_data", w_rd_data[0], 32'h77);
        cnt = 0;
        while (w_busy[0] === 1'b1 && cnt < 100) begin
            cnt++;
            rd(cnt % 32);
            chk("busy_no_valid", 32'(w_rd_valid[0]), 32'd0);
        end
        chk("clr_len_req", 32'(cnt), 32'd32);
        for (int i = 0; i < 32; i++) begin
            rd(i);
            chk("post_clr_zero", w_rd_data[0], 32'h0);
        end

        // out-of-range access on the 20-word instance
        for (int i = 0; i < 20; i++) wr(i, 32'hA5000000 + i, 4'hF);
        wr(25, 32'hCAFEF00D, 4'hF);
        rd(25);
        chk("oor_dut0_data", w_rd_data[0], 32'hCAFEF00D);
        tick();
        chk("oor_valid", 32'(w_rd_valid[1]), 32'd1);
        chk("oor_data", w_rd_data[1], 32'h0);
        for (int i = 0; i < 20; i++) rd(i);
        tick();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            r_rst     = ($urandom_range(0, 399) == 0);
            r_clear   = ($urandom_range(0, 99) == 0);
            r_wr_en   = 1'($urandom_range(0, 1));
            r_wr_addr = 5'($urandom_range(0, 31));
            r_wr_be   = 4'($urandom);
            r_wr_data = $urandom;
            r_rd_en   = 1'($urandom_range(0, 1));
            r_rd_addr = ($urandom_range(0, 3) == 0) ? r_wr_addr : 5'($urandom_range(0, 31));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
